// File: rtl/sll_share_arb_if.sv
// Request/response bundle between two requesters and the shared shifter arbiter.
// Requesters use the master modport, the arbiter the slave modport.
interface sll_share_arb_if;
  logic        req0_valid;
  logic        req1_valid;
  logic [31:0] req0_a;
  logic [31:0] req1_a;
  logic [4:0]  req0_shamt;
  logic [4:0]  req1_shamt;
  logic        req0_ready;
  logic        req1_ready;
  logic        rsp0_valid;
  logic        rsp1_valid;
  logic [31:0] rsp0_y;
  logic [31:0] rsp1_y;
  logic        rsp0_ready;
  logic        rsp1_ready;

  modport master (
    output req0_valid, req1_valid,
    output req0_a, req1_a,
    output req0_shamt, req1_shamt,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid,
    input  rsp0_y, rsp1_y,
    output rsp0_ready, rsp1_ready
  );

  modport slave (
    input  req0_valid, req1_valid,
    input  req0_a, req1_a,
    input  req0_shamt, req1_shamt,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid,
    output rsp0_y, rsp1_y,
    input  rsp0_ready, rsp1_ready
  );
endinterface

// File: rtl/sll_share_arb.sv
// Round-robin arbiter/sequencer sharing one 32-bit logical-left shifter
// between two requesters: accept, shift, then hold until consumed.
module sll_share_arb #(
  parameter bit PRIO_RESET = 1'b0
) (
  input  logic clock,
  input  logic ctrl_reset_n,
  sll_share_arb_if.slave bus,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] op_a_q, op_a_d;
  logic [4:0]  op_sh_q, op_sh_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        rsp0_valid_q, rsp0_valid_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic [31:0] rsp0_y_q, rsp0_y_d;
  logic [31:0] rsp1_y_q, rsp1_y_d;
  logic        win;
  logic        any_req;
  logic        rdy0, rdy1;
  logic [31:0] shifted;

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q      <= IDLE;
      op_a_q       <= '0;
      op_sh_q      <= '0;
      gnt_q        <= 1'b0;
      last_q       <= ~PRIO_RESET;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_y_q     <= '0;
      rsp1_y_q     <= '0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_sh_q      <= op_sh_d;
      gnt_q        <= gnt_d;
      last_q       <= last_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_y_q     <= rsp0_y_d;
      rsp1_y_q     <= rsp1_y_d;
    end
  end

  assign shifted = op_a_q << op_sh_q;

  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_sh_d      = op_sh_q;
    gnt_d        = gnt_q;
    last_d       = last_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp0_y_d     = rsp0_y_q;
    rsp1_y_d     = rsp1_y_q;
    rdy0         = 1'b0;
    rdy1         = 1'b0;
    any_req      = bus.req0_valid | bus.req1_valid;
    // On a tie the requester not served last wins.
    win = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;
    unique case (state_q)
      IDLE: begin
        // Ready is masked during reset since state reads IDLE then.
        if (ctrl_reset_n && any_req) begin
          rdy0    = ~win;
          rdy1    = win;
          op_a_d  = win ? bus.req1_a : bus.req0_a;
          op_sh_d = win ? bus.req1_shamt : bus.req0_shamt;
          gnt_d   = win;
          last_d  = win;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (gnt_q) begin
          rsp1_y_d     = shifted;
          rsp1_valid_d = 1'b1;
        end else begin
          rsp0_y_d     = shifted;
          rsp0_valid_d = 1'b1;
        end
        state_d = HOLD;
      end
      HOLD: begin
        if (gnt_q ? bus.rsp1_ready : bus.rsp0_ready) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp0_y     = rsp0_y_q;
  assign bus.rsp1_y     = rsp1_y_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: doc/sll_share_arb.md
# sll_share_arb

Two-requester arbiter and sequencer for the shared 32-bit logical-left barrel shifter. Each requester presents an operand and shift amount over a valid/ready handshake. The block grants one request at a time (round-robin), registers the operands, drives the shifter and holds the registered result on that requester's response port until it is consumed. It sits between the ALU issue logic and the single shifter instance, so the ALU and the multiply/rotate helper can share one shifter.

## Interface
- `PRIO_RESET`, default 0: requester that wins the first tie after reset (0 or 1).
- `clock`  in  1: single clock; all state updates on the rising edge.
- `ctrl_reset_n`  in  1: asynchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1 each: request pending.
- `req0_a`, `req1_a`  in  32 each: value to shift.
- `req0_shamt`, `req1_shamt`  in  5 each: shift amount, 0..31.
- `req0_ready`, `req1_ready`  out  1 each: request accepted this cycle.
- `rsp0_valid`, `rsp1_valid`  out  1 each: result available.
- `rsp0_y`, `rsp1_y`  out  32 each: shifted result, `a << shamt`, zero-filled.
- `rsp0_ready`, `rsp1_ready`  in  1 each: result consumed this cycle.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- Internal state:
  - `op_a[31:0]`, `op_sh[4:0]`: operand registers feeding the shifter.
  - `gnt`: 1-bit owner of the current operation.
  - `last`: 1-bit, last granted requester.
  - FSM with states IDLE, SHIFT, HOLD.
- **IDLE:**
  - Select a winner:
    - only one `reqN_valid` high: that requester wins;
    - both high: winner = `~last`.
  - `reqN_ready` is asserted combinationally for the winner only. It is never high for both requesters, and never high outside IDLE.
  - On the accept edge: `op_a`/`op_sh` load the winner's inputs, `gnt` = winner, `last` = winner, go to SHIFT.
  - No valid request: stay in IDLE.
- **SHIFT:**
  - Shifter output (`op_a << op_sh`) is registered into the `rsp_y` register of port `gnt`.
  - `rsp{gnt}_valid` is set; go to HOLD.
- **HOLD:**
  - `rsp{gnt}_valid` stays high and `rsp{gnt}_y` stays stable until `rsp{gnt}_ready` is sampled high.
  - On that edge: clear `rsp{gnt}_valid`, go to IDLE.
  - The `rsp_ready` of the non-owning port is ignored.
- Requests are not accepted in SHIFT or HOLD. A requester must hold `valid` and its data stable until it sees `ready`. The arbiter does not check this.
- Width rules:
  - Shift amount is taken modulo 32 by construction (5 bits).
  - Bits shifted out are lost; vacated LSBs are 0.
  - `shamt` = 0 passes `a` through unchanged.
- `rsp_y` holds its last value after `valid` drops. Only `valid` qualifies it.

## Timing
- Reset values (asynchronous, on `ctrl_reset_n` low):
  - state = IDLE, `op_a` = 0, `op_sh` = 0, `gnt` = 0;
  - `last` = `~PRIO_RESET`;
  - `rsp0_valid` = `rsp1_valid` = 0, `rsp0_y` = `rsp1_y` = 0, `busy` = 0.
  - `req_ready` outputs are low while reset is asserted.
- Latency: accept on edge T; `rsp_valid` goes high after edge T+1 and is visible in cycle T+1..T+2.
- Throughput: best case one operation per 3 cycles (accept, shift, consume). An immediately-ready consumer gives `rsp_valid` a one-cycle pulse.
- Consume and new request in the same cycle: the HOLD→IDLE edge does not accept. The new request is accepted on the following IDLE cycle.
- A requester whose request was just served loses the next tie if the other requester is valid.
- Reset mid-operation (SHIFT or HOLD): the operation is abandoned, no response is produced, and everything returns to reset values.

## Test plan
- **Reset:** assert `ctrl_reset_n` = 0 asynchronously mid-cycle → all `rsp_valid` = 0, `busy` = 0, `req_ready` = 0 immediately. After release, with nothing requested, the outputs stay idle.
- **Single request:** `req0` a = 0x0000_00FF, shamt = 4, `rsp0_ready` = 1 → `req0_ready` in cycle 0; `rsp0_valid` in cycle 2 with `rsp0_y` = 0x0000_0FF0; `busy` high in cycles 1–2.
- **Tie with PRIO_RESET = 0:** both valid from reset (`req0` a = 1, shamt = 31; `req1` a = 0xFFFF_FFFF, shamt = 0) → `req0` granted first with `rsp0_y` = 0x8000_0000; `req1` granted next with `rsp1_y` = 0xFFFF_FFFF; a continued tie alternates 0, 1, 0, 1.
- **Backpressure:** `rsp1_ready` held low for 5 cycles → `rsp1_valid` and `rsp1_y` stable throughout; `req0_ready` never asserts; `rsp1_ready` high → next cycle IDLE, and `req0` is accepted one cycle later.
- **Reset mid-operation:** reset in HOLD → no response delivered; the first grant after release follows `PRIO_RESET`.
- **Sweep:** random a, all shamt 0..31 on both ports with random ready stalls → every response equals `(a << shamt)` masked to 32 bits, in issue order per port, with none lost or duplicated.
